// File: rtl/led_periph_pkg.sv
// Shared definitions for the LED peripheral bus: register addresses,
// control values and the pattern-sequencer state encoding.
package led_periph_pkg;

  localparam logic [7:0] LED_NONE    = 8'h00;
  localparam logic [7:0] LED_CONTROL = 8'h01;
  localparam logic [7:0] LED_DATA_01 = 8'h02;
  localparam logic [7:0] LED_DATA_02 = 8'h03;

  localparam logic [7:0] CTRL_ON  = 8'h01;
  localparam logic [7:0] CTRL_OFF = 8'h00;

  localparam int PATTERN_W = 16;
  localparam int IDX_W     = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR_HI,
    WR_LO,
    SHOW,
    BLANK
  } seq_state_t;

endpackage

// File: rtl/led_pattern_rom.sv
// Fixed LED pattern table: 3-bit index to 16-bit pattern, purely combinational
// so any pattern source can register the result as it sees fit.
module led_pattern_rom
  import led_periph_pkg::*;
(
  input  logic [IDX_W-1:0]     idx,
  output logic [PATTERN_W-1:0] pattern
);

  always_comb begin
    // NOTE: assign every always_comb output before the case so no path leaves it unassigned (no latch).
    pattern = '0;
    case (idx)
      3'd0: pattern = 16'h0001;
      3'd1: pattern = 16'h0003;
      3'd2: pattern = 16'h0007;
      3'd3: pattern = 16'h000F;
      3'd4: pattern = 16'h00FF;
      3'd5: pattern = 16'h0FFF;
      3'd6: pattern = 16'hFFFF;
      3'd7: pattern = 16'hAAAA;
      default: pattern = '0;
    endcase
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Bus master that walks the pattern table, writing high byte, low byte, then
// holding the control register on for HOLD_CYCLES cycles per pattern.
module led_pattern_sequencer
  import led_periph_pkg::*;
#(
  parameter int NUM_PATTERNS = 8,
  parameter int HOLD_CYCLES  = 16,
  parameter int CNT_W        = $clog2(HOLD_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic [7:0]       data_address,
  output logic [7:0]       write_data,
  output logic             wr_en,
  output logic             busy,
  output logic             frame_done,
  output logic [IDX_W-1:0] pattern_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

  seq_state_t            state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [IDX_W-1:0]      idx_next;
  logic [PATTERN_W-1:0]  pattern;
  logic [7:0]            addr_next, data_next;
  logic                  wr_next, busy_next, frame_done_next;

  // Looked up with the next index so the registered data matches the next state.
  led_pattern_rom u_rom (
    .idx     (idx_next),
    .pattern (pattern)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = pattern_idx;
    unique case (state)
      IDLE: begin
        idx_next = '0;
        if (start && !stop) state_next = WR_HI;
      end
      WR_HI: state_next = stop ? BLANK : WR_LO;
      WR_LO: begin
        if (stop) begin
          state_next = BLANK;
        end else begin
          state_next = SHOW;
          cnt_next   = '0;
        end
      end
      SHOW: begin
        if (stop) begin
          state_next = BLANK;
        end else if (cnt == LAST_CNT) begin
          if (pattern_idx != LAST_IDX) begin
            idx_next   = pattern_idx + IDX_W'(1);
            state_next = WR_HI;
          end else if (loop_en) begin
            idx_next   = '0;
            state_next = WR_HI;
          end else begin
            state_next = BLANK;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      BLANK: begin
        idx_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change on
  // the same edge the transition is taken and never see inputs combinationally.
  always_comb begin
    addr_next       = LED_NONE;
    data_next       = 8'h00;
    wr_next         = 1'b0;
    frame_done_next = 1'b0;
    busy_next       = (state_next != IDLE);
    unique case (state_next)
      WR_HI: begin
        addr_next = LED_DATA_01;
        data_next = pattern[15:8];
        wr_next   = 1'b1;
      end
      WR_LO: begin
        addr_next = LED_DATA_02;
        data_next = pattern[7:0];
        wr_next   = 1'b1;
      end
      SHOW: begin
        addr_next       = LED_CONTROL;
        data_next       = CTRL_ON;
        wr_next         = 1'b1;
        frame_done_next = (cnt_next == LAST_CNT);
      end
      BLANK: begin
        addr_next = LED_CONTROL;
        data_next = CTRL_OFF;
        wr_next   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pattern_idx  <= '0;
      data_address <= LED_NONE;
      write_data   <= 8'h00;
      wr_en        <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state        <= state_next;
      cnt          <= cnt_next;
      pattern_idx  <= idx_next;
      data_address <= addr_next;
      write_data   <= data_next;
      wr_en        <= wr_next;
      busy         <= busy_next;
      frame_done   <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: two sequencer configurations driven by directed and
// random stimulus, compared every cycle against an arithmetic timeline model.
module tb_led_pattern_sequencer;

  logic clk = 1'b0;
  logic rst, start, stop, loop_en;

  logic [7:0] addr_a, data_a, addr_b, data_b;
  logic       wr_a, busy_a, fd_a, wr_b, busy_b, fd_b;
  logic [2:0] idx_a, idx_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.NUM_PATTERNS(8), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .data_address(addr_a), .write_data(data_a), .wr_en(wr_a),
    .busy(busy_a), .frame_done(fd_a), .pattern_idx(idx_a)
  );

  led_pattern_sequencer #(.NUM_PATTERNS(1), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .data_address(addr_b), .write_data(data_b), .wr_en(wr_b),
    .busy(busy_b), .frame_done(fd_b), .pattern_idx(idx_b)
  );

  // Reference model: a run is a timeline t counted from the start edge; the
  // frame is t / (hold+2) and the phase inside the frame is t % (hold+2).
  int          hold_c [2] = '{4, 1};
  int          num_p  [2] = '{8, 1};
  logic [15:0] pat_tab [8] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F,
                               16'h00FF, 16'h0FFF, 16'hFFFF, 16'hAAAA};
  int m_t   [2];
  bit m_run [2];
  bit m_blank [2];
  int m_idx [2];

  int busy_cnt_a, fd_cnt_a, busy_cnt_b, fd_cnt_b, cyc;

  function automatic logic [21:0] expect_out(int i);
    int p, f;
    logic [15:0] pw;
    if (m_blank[i]) return {8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 3'(m_idx[i])};
    if (!m_run[i])  return '0;
    p  = m_t[i] % (hold_c[i] + 2);
    f  = (m_t[i] / (hold_c[i] + 2)) % num_p[i];
    pw = pat_tab[f];
    if (p == 0) return {8'h02, pw[15:8], 1'b1, 1'b1, 1'b0, 3'(f)};
    if (p == 1) return {8'h03, pw[7:0], 1'b1, 1'b1, 1'b0, 3'(f)};
    return {8'h01, 8'h01, 1'b1, 1'b1, (p == hold_c[i] + 1), 3'(f)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_blank[i] = 0; m_t[i] = 0; m_idx[i] = 0;
    end
  endtask

  task automatic model_clock();
    int period, f;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      period = hold_c[i] + 2;
      if (m_blank[i]) begin
        m_blank[i] = 0;
        m_idx[i]   = 0;
      end else if (!m_run[i]) begin
        if (start && !stop) begin
          m_run[i] = 1;
          m_t[i]   = 0;
        end
      end else begin
        f = (m_t[i] / period) % num_p[i];
        if (stop || (m_t[i] % period == period - 1 && f == num_p[i] - 1 && !loop_en)) begin
          m_run[i]   = 0;
          m_blank[i] = 1;
          m_idx[i]   = f;
        end else begin
          m_t[i]++;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_a"}, {10'b0, addr_a, data_a, wr_a, busy_a, fd_a, idx_a}, {10'b0, expect_out(0)});
    check({tag, "_b"}, {10'b0, addr_b, data_b, wr_b, busy_b, fd_b, idx_b}, {10'b0, expect_out(1)});
  endtask

  task automatic step(input string tag = "cycle");
    @(posedge clk);
    model_clock();
    #1;
    compare_all(tag);
    if (busy_a) busy_cnt_a++;
    if (fd_a)   fd_cnt_a++;
    if (busy_b) busy_cnt_b++;
    if (fd_b)   fd_cnt_b++;
  endtask

  task automatic clear_counts();
    busy_cnt_a = 0; fd_cnt_a = 0; busy_cnt_b = 0; fd_cnt_b = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    model_reset();
    clear_counts();
    #1;
    compare_all("reset");
    check("reset_outputs_a", {addr_a, data_a, wr_a, busy_a, fd_a, idx_a}, 32'h0);
    repeat (2) step("reset_hold");
    rst = 1'b0;
    repeat (3) step("idle");

    // start and stop together in IDLE: stay idle
    start = 1'b1; stop = 1'b1;
    step("start_stop");
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy_a, 0);
    step("idle");

    // Non-looping run, with a stray start pulse during WR_LO
    clear_counts();
    start = 1'b1;
    step("run1");
    start = 1'b0;
    step("run1");
    start = 1'b1;
    step("run1_start_ignored");
    start = 1'b0;
    for (int c = 0; c < 80 && busy_a; c++) step("run1");
    check("run1_finished", busy_a, 0);
    check("run1_busy_cycles_a", busy_cnt_a, 49);
    check("run1_frame_done_a", fd_cnt_a, 8);
    check("run1_busy_cycles_b", busy_cnt_b, 4);
    check("run1_frame_done_b", fd_cnt_b, 1);

    // Looping run: ninth frame_done lands on cycle 54 counting the start edge
    loop_en = 1'b1;
    clear_counts();
    start = 1'b1;
    step("loop");
    start = 1'b0;
    cyc = 1;
    while (fd_cnt_a < 9 && cyc < 100) begin
      step("loop");
      cyc++;
    end
    check("loop_ninth_fd_cycle", cyc, 54);
    stop = 1'b1;
    step("loop_stop");
    stop = 1'b0;
    check("loop_stop_blank", {addr_a, data_a, wr_a}, {8'h01, 8'h00, 1'b1});
    step("loop_idle");
    check("loop_stop_idle_busy", busy_a, 0);

    // Stop on the second SHOW cycle of entry 3
    loop_en = 1'b0;
    clear_counts();
    start = 1'b1;
    step("run3");
    start = 1'b0;
    repeat (21) step("run3");
    check("run3_show_entry3", {addr_a, data_a, idx_a}, {8'h01, 8'h01, 3'd3});
    stop = 1'b1;
    step("run3_stop");
    stop = 1'b0;
    check("run3_blank", {addr_a, data_a, wr_a, fd_a}, {8'h01, 8'h00, 1'b1, 1'b0});
    step("run3_idle");
    check("run3_idle", {addr_a, wr_a, busy_a, idx_a}, 32'h0);
    check("run3_frame_done_a", fd_cnt_a, 3);

    // Asynchronous reset in the middle of SHOW
    start = 1'b1;
    step("run4");
    start = 1'b0;
    repeat (3) step("run4");
    check("run4_in_show", addr_a, 8'h01);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("async_reset");
    check("async_reset_zero_a", {addr_a, data_a, wr_a, busy_a, fd_a, idx_a}, 32'h0);
    step("reset_hold");
    rst = 1'b0;
    repeat (4) step("post_reset_idle");
    check("post_reset_busy", busy_a, 0);

    // Random traffic on start, stop and loop_en
    for (int n = 0; n < 1500; n++) begin
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      loop_en = 1'($urandom_range(0, 1));
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Autonomous bus master that drives the LED peripheral's register write port. It steps through a fixed table of 16-bit LED patterns and, for each pattern, writes the high byte, writes the low byte, then holds the control register enabled for a programmable number of cycles. It sits directly upstream of the LED peripheral. Its `data_address`, `write_data` and `wr_en` outputs connect one-to-one to the peripheral inputs of the same names.

## Interface
- `NUM_PATTERNS`, default 8: table entries used, range 1..8.
- `HOLD_CYCLES`, default 16: cycles each pattern is displayed, must be ≥ 1.
- `CNT_W`, default `$clog2(HOLD_CYCLES+1)`: hold counter width.
- `clk` in, 1: clock.
- `rst` in, 1: reset, asynchronous, active-high.
- `start` in, 1: begin sequence; sampled in IDLE only.
- `stop` in, 1: abort sequence; sampled in any state.
- `loop_en` in, 1: 1 wraps from the last entry to entry 0; 0 ends after the last entry.
- `data_address` out, 8: peripheral register address.
- `write_data` out, 8: peripheral write data.
- `wr_en` out, 1: peripheral write enable.
- `busy` out, 1: high in every state except IDLE.
- `frame_done` out, 1: one-cycle pulse on the last hold cycle of each pattern.
- `pattern_idx` out, 3: index of the current table entry.

## Operation
- All outputs come directly from flops. There is no combinational path from inputs to outputs.
- Peripheral addresses: 0x01 = control (bit0 enables display), 0x02 = LED data high byte, 0x03 = LED data low byte. Any other address makes the peripheral blank the LEDs.
- Pattern table, entries 0..7: 0x0001, 0x0003, 0x0007, 0x000F, 0x00FF, 0x0FFF, 0xFFFF, 0xAAAA.
- States:
  - IDLE: outputs `addr`=0x00, `data`=0x00, `wr_en`=0; `pattern_idx`=0; `busy`=0.
  - WR_HI: outputs `addr`=0x02, `data`=`pattern[15:8]`, `wr_en`=1. Lasts one cycle, then WR_LO.
  - WR_LO: outputs `addr`=0x03, `data`=`pattern[7:0]`, `wr_en`=1. Lasts one cycle, then SHOW. The hold counter loads 0.
  - SHOW: outputs `addr`=0x01, `data`=0x01, `wr_en`=1. Lasts exactly `HOLD_CYCLES` cycles. On the last cycle `frame_done`=1, then:
    - if `pattern_idx`≠`NUM_PATTERNS-1`: `idx`+1, go to WR_HI;
    - if last entry and `loop_en`=1: `idx`=0, go to WR_HI;
    - otherwise go to BLANK.
  - BLANK: outputs `addr`=0x01, `data`=0x00, `wr_en`=1. Lasts one cycle, then IDLE.
- IDLE → WR_HI when `start`=1 and `stop`=0.
- `stop`=1 in WR_HI, WR_LO or SHOW → BLANK next cycle. The write in progress is abandoned and `frame_done` is not pulsed.
- `stop` in BLANK or IDLE has no effect.
- `start` while `busy`=1 is ignored. `start` and `stop` together in IDLE: stay in IDLE.
- `loop_en` is sampled only on the last SHOW cycle.
- Reset drives every output to 0 (`addr` 0x00, `data` 0x00, `wr_en` 0, `busy` 0, `frame_done` 0, `pattern_idx` 0), the state to IDLE and the counter to 0.
- Reset mid-sequence aborts immediately. No BLANK write is issued; the peripheral blanks anyway because it sees address 0x00.

## Timing
- `start` sampled at edge k → WR_HI outputs are valid from edge k; `busy`=1 from edge k.
- Frame period is `HOLD_CYCLES`+2 cycles. A non-looping run lasts `NUM_PATTERNS`×(`HOLD_CYCLES`+2)+1 cycles, including BLANK.
- The peripheral registers its inputs and acts one cycle later, so LED updates lag the sequencer outputs by 2 cycles. Back-to-back single-cycle writes are legal.
- `stop` sampled at edge k → BLANK outputs from edge k, IDLE outputs from edge k+1.

## Structure
- Shared package `led_periph_pkg`:
  - address constants `LED_CONTROL`=0x01, `LED_DATA_01`=0x02, `LED_DATA_02`=0x03;
  - the state enum (IDLE, WR_HI, WR_LO, SHOW, BLANK).
- Sub-module `led_pattern_rom`: a combinational 3-bit index → 16-bit pattern lookup. Reused by later pattern sources.

## Test plan
- Reset asserted during SHOW → all outputs 0 on the same edge. After release, state stays IDLE until `start`.
- `HOLD_CYCLES`=4, `loop_en`=0, `start` pulse → output sequence (02,00,1), (03,01,1), (01,01,1)×4, and so on for all 8 entries, then (01,00,1) once, then idle. Total 49 busy cycles, 8 `frame_done` pulses. A connected peripheral shows 0x0001 … 0xAAAA, then 0x0000.
- `loop_en`=1 → after entry 7 the next write is (02,00,1) with `pattern_idx`=0. The 9th `frame_done` occurs 54 cycles after start.
- `stop` on the 2nd SHOW cycle of entry 3 → next cycle (01,00,1), then IDLE outputs, `pattern_idx`=0, no `frame_done` for entry 3. Peripheral LEDs read 0x0000 within 3 cycles.
- `start` pulsed during WR_LO → sequence unchanged. `start`+`stop` together in IDLE → `busy` stays 0.
- `NUM_PATTERNS`=1, `HOLD_CYCLES`=1, `loop_en`=0 → exactly 4 busy cycles: WR_HI, WR_LO, SHOW (with `frame_done`), BLANK.
